regfile_sb: RTL and testbench

Parametrised register file for the RISC-V core with N combinational read ports, one write port, optional write-to-read bypass, and a per-register scoreboard of pending bits for in-flight producers. A sequential clear sweep zeroes the storage after reset, and a `ready` flag gates normal operation while the sweep runs. It replaces the fixed 2-read/1-write, 32×32 register file between decode (reads, reservations) and writeback (writes).

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_rdport.sv | 28 ++
 rtl/regfile_sb.sv | 73 +++++++
 tb/tb_regfile_sb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state enum and default sizes for regfile_sb
package regfile_pkg;
  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port (run gate, storage mux, write bypass, zero-register mask); in regs/pend/wr_*, addr; out data/busy
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              run,
  input  logic [NREG*XLEN-1:0] regs,
  input  logic [NREG-1:0]   pend,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [AW-1:0]     addr,
  output logic [XLEN-1:0]   data,
  output logic              busy
);
  logic mask, byp;
  always_comb begin
    mask = !run || (ZERO_REG != 0 && addr == '0);
    byp = BYPASS != 0 && wr_en && wr_addr == addr;
    data = mask ? '0 : byp ? wr_data : regs[int'(addr)*XLEN +: XLEN];
    busy = !mask && !byp && pend[addr];
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NRD read ports, one write port, pending-bit scoreboard and post-reset clear sweep
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                dbl_rsv
);
  rf_state_e state, state_n;
  logic [AW-1:0] idx;
  logic [XLEN-1:0] mem [NREG];
  logic [NREG*XLEN-1:0] flat;
  logic [NREG-1:0] pend, pend_n;
  logic clr, we, rv;
  always_ff @(posedge clk)
    if (rst) state <= RF_CLEAR;
    else state <= state_n;
  always_comb state_n = (state == RF_CLEAR && idx == AW'(NREG - 1)) ? RF_RUN : state;
  always_comb begin
    ready = state == RF_RUN;
    clr = state == RF_CLEAR;
    we = ready && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    rv = ready && rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  end
  always_ff @(posedge clk)
    if (rst) idx <= '0;
    else if (clr) idx <= idx + 1'b1;
  always_ff @(posedge clk)
    if (clr) mem[idx] <= '0;
    else if (we) mem[wr_addr] <= wr_data;
  always_comb begin
    pend_n = pend;
    if (we) pend_n[wr_addr] = 1'b0;
    if (rv) pend_n[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) pend <= '0;
    else pend <= pend_n;
  always_ff @(posedge clk)
    if (rst) dbl_rsv <= 1'b0;
    else if (rv && pend[rsv_addr] && !(we && wr_addr == rsv_addr)) dbl_rsv <= 1'b1;
  always_comb
    for (int k = 0; k < NREG; k++) flat[k*XLEN +: XLEN] = mem[k];
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_rd (
      .run(ready),
      .regs(flat),
      .pend(pend),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .addr(rs_addr[i*AW +: AW]),
      .data(rs_data[i*XLEN +: XLEN]),
      .busy(rs_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed scoreboard bench for regfile_sb against an array-based reference model
module tb_regfile_sb;
  logic clk = 0;
  logic rst = 1;
  logic ready, dbl_rsv;
  logic [9:0] rs_addr = '0;
  logic [63:0] rs_data;
  logic [1:0] rs_busy;
  logic wr_en = 0, rsv_en = 0;
  logic [4:0] wr_addr = '0, rsv_addr = '0;
  logic [31:0] wr_data = '0;
  int tests = 0, fails = 0;
  typedef struct {
    logic rdy;
    logic [31:0] d0, d1;
    logic b0, b1, dbl;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_mem [32];
  bit m_pend [32];
  bit m_dbl;
  int m_cnt;
  always #5 clk = ~clk;
  regfile_sb dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .dbl_rsv(dbl_rsv)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void port_exp(input logic [4:0] a, output logic [31:0] d, output logic b);
    if (m_cnt < 32 || a == 0) begin
      d = '0;
      b = 0;
    end else if (wr_en && wr_addr == a) begin
      d = wr_data;
      b = 0;
    end else begin
      d = m_mem[a];
      b = m_pend[a];
    end
  endfunction
  task automatic apply(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = rv; rsv_addr = ra; rs_addr = {a1, a0};
    e.rdy = m_cnt >= 32;
    e.dbl = m_dbl;
    port_exp(a0, e.d0, e.b0);
    port_exp(a1, e.d1, e.b1);
    q.push_back(e);
    #1;
  endtask
  task automatic tick();
    bit old;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_dbl = 0;
      for (int k = 0; k < 32; k++) begin
        m_mem[k] = '0;
        m_pend[k] = 0;
      end
    end else if (m_cnt < 32) m_cnt++;
    else begin
      old = m_pend[rsv_addr];
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr] = wr_data;
        m_pend[wr_addr] = 0;
      end
      if (rsv_en && rsv_addr != 0) begin
        if (old && !(wr_en && wr_addr == rsv_addr)) m_dbl = 1;
        m_pend[rsv_addr] = 1;
      end
    end
    #1;
  endtask
  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    apply(0, 0, 0, 0, 0, 0, a0, a1);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ready", 32'(ready), 32'(e.rdy));
      chk("rs_data0", rs_data[31:0], e.d0);
      chk("rs_data1", rs_data[63:32], e.d1);
      chk("rs_busy0", 32'(rs_busy[0]), 32'(e.b0));
      chk("rs_busy1", 32'(rs_busy[1]), 32'(e.b1));
      chk("dbl_rsv", 32'(dbl_rsv), 32'(e.dbl));
    end
  initial begin
    int first;
    m_cnt = 0;
    m_dbl = 0;
    @(posedge clk);
    #1;
    repeat (2) begin
      apply(1, 0, 0, 0, 0, 0, 5, 0);
      tick();
    end
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      idle(5, 0);
      tick();
      if (ready && first == 0) first = n;
    end
    chk("sweep_len", 32'(first), 32'd32);
    apply(0, 1, 1, 32'hA5A5A5A5, 0, 0, 1, 0);
    chk("bypass_x1", rs_data[31:0], 32'hA5A5A5A5);
    tick();
    idle(1, 0);
    chk("stored_x1", rs_data[31:0], 32'hA5A5A5A5);
    chk("read_x0", rs_data[63:32], 32'h0);
    tick();
    apply(0, 0, 0, 0, 1, 3, 3, 0);
    tick();
    idle(3, 0);
    chk("busy_x3", 32'(rs_busy[0]), 32'd1);
    tick();
    apply(0, 1, 3, 32'h12345678, 0, 0, 3, 3);
    chk("byp_busy_x3", 32'(rs_busy[0]), 32'd0);
    chk("byp_data_x3", rs_data[31:0], 32'h12345678);
    tick();
    idle(3, 0);
    chk("busy_x3_after", 32'(rs_busy[0]), 32'd0);
    tick();
    apply(0, 1, 4, 32'hFF, 1, 4, 0, 0);
    tick();
    idle(4, 0);
    chk("coll_data", rs_data[31:0], 32'hFF);
    chk("coll_busy", 32'(rs_busy[0]), 32'd1);
    chk("coll_dbl", 32'(dbl_rsv), 32'd0);
    tick();
    apply(0, 0, 0, 0, 1, 4, 4, 0);
    tick();
    idle(4, 0);
    chk("dbl_set", 32'(dbl_rsv), 32'd1);
    tick();
    apply(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    chk("x0_byp", rs_data[31:0], 32'h0);
    tick();
    idle(0, 0);
    chk("x0_data", rs_data[31:0], 32'h0);
    chk("x0_busy", 32'(rs_busy[0]), 32'd0);
    chk("dbl_sticky", 32'(dbl_rsv), 32'd1);
    tick();
    apply(1, 0, 0, 0, 0, 0, 1, 4);
    tick();
    for (int n = 0; n < 32; n++) begin
      idle(1, 4);
      tick();
    end
    idle(1, 4);
    chk("run_rst_x1", rs_data[31:0], 32'h0);
    chk("run_rst_busy", 32'(rs_busy), 32'd0);
    chk("run_rst_dbl", 32'(dbl_rsv), 32'd0);
    tick();
    apply(1, 0, 0, 0, 0, 0, 2, 3);
    tick();
    repeat (10) begin
      idle(2, 3);
      tick();
    end
    apply(1, 0, 0, 0, 0, 0, 2, 3);
    tick();
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      idle(2, 3);
      tick();
      if (ready && first == 0) first = n;
    end
    chk("resweep_len", 32'(first), 32'd32);
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(0, 149) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end
    idle(0, 0);
    #10;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
